// File: rtl/packet_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous packet-memory read port among
// several BPF cores. Each grant travels down an RD_LATENCY-deep pipeline and
// returns a one-cycle req_valid pulse to its core, together with mem_data.
// A core stays stalled from the cycle it raises req_rd_en up to and including
// its grant cycle, and keeps stalling until its req_valid cycle.
module packet_mem_arbiter #(
    parameter int unsigned N_CORES    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CORES-1:0]            req_rd_en,
    input  logic [N_CORES*ADDR_WIDTH-1:0] req_addr,
    output logic [N_CORES-1:0]            req_stall,
    output logic [N_CORES-1:0]            req_valid,
    output logic [DATA_WIDTH-1:0]         req_data,
    output logic                          mem_rd_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_data
);

    localparam int unsigned IdxW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    typedef logic [IdxW-1:0] idx_t;

    logic [N_CORES-1:0]    busy_q, busy_d;
    logic [N_CORES-1:0]    eligible;
    logic [N_CORES-1:0]    grant;
    idx_t                  ptr_q, ptr_d;
    idx_t                  gnt_idx;
    idx_t                  cand;
    logic                  gnt_vld;
    logic [RD_LATENCY-1:0] pipe_vld_q;
    idx_t                  pipe_idx_q [RD_LATENCY];

    // A core that already has a read in flight is masked until its data returns.
    assign eligible = req_rd_en & ~busy_q;

    // Pick the first eligible core at or after the pointer; nothing is granted in reset.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        grant   = '0;
        for (int k = 0; k < int'(N_CORES); k++) begin
            cand = idx_t'((int'(ptr_q) + k) % int'(N_CORES));
            if (rst && !gnt_vld && eligible[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        grant[gnt_idx] = gnt_vld;
    end

    // Memory request and pointer advance follow directly from the grant.
    always_comb begin
        mem_rd_en = gnt_vld;
        mem_addr  = gnt_vld ? req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        ptr_d     = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == idx_t'(N_CORES - 1)) ? '0 : idx_t'(gnt_idx + 1'b1);
        end
    end

    // Return path: last pipeline stage selects which core sees the data.
    always_comb begin
        req_valid = '0;
        if (pipe_vld_q[RD_LATENCY-1]) begin
            req_valid[pipe_idx_q[RD_LATENCY-1]] = 1'b1;
        end
        req_data  = mem_data;
        busy_d    = (busy_q | grant) & ~req_valid;
        // Waiting or in-flight cores freeze; stall drops in the valid cycle.
        req_stall = (req_rd_en & ~busy_q) | (busy_q & ~req_valid);
    end

    // State: busy mask, priority pointer and the grant pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            ptr_q      <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pipe_idx_q[i] <= '0;
            end
        end else begin
            busy_q        <= busy_d;
            ptr_q         <= ptr_d;
            pipe_vld_q[0] <= gnt_vld;
            pipe_idx_q[0] <= gnt_idx;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

endmodule
